pat_sequencer: RTL and testbench
================================

Name: pat_sequencer

Overview:
Scheduler that feeds the pattern-consumer datapath. It holds a small table of patterns, each with a per-entry repeat count. On start it emits table entries in order as one AXI-Stream beat per frame-pattern, repeating each entry and looping the table a programmed number of times. It sits between the host configuration logic and the consumer's pattern input stream, and reports busy, done and a beat count back to the host.

Parameters:
PATTERN_WIDTH, 32, width of one pattern word (matches consumer input width)
ADDR_W, 4, table address width; table depth DEPTH = 2**ADDR_W
REPEAT_W, 16, width of per-entry repeat count and loop count

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
cfg_wr  in  1  table write strobe, one entry per cycle
cfg_addr  in  ADDR_W  table entry written
cfg_pattern  in  PATTERN_WIDTH  pattern value for entry
cfg_repeat  in  REPEAT_W  beats to emit for entry; 0 treated as 1
num_entries  in  ADDR_W+1  entries used per pass, sampled at start
loop_count  in  REPEAT_W  table passes, sampled at start; 0 = loop forever
start  in  1  single-cycle start request
stop  in  1  single-cycle stop request
AXIS_OUT_TDATA  out  PATTERN_WIDTH  pattern to consumer, registered
AXIS_OUT_TVALID  out  1  beat valid
AXIS_OUT_TREADY  in  1  consumer ready
busy  out  1  high from start acceptance until return to IDLE
done  out  1  one-cycle pulse on normal or stopped completion
beats_sent  out  32  handshakes since last accepted start, wraps at 2**32

Behaviour:
- Reset (any state, mid-beat included): state=IDLE, TVALID=0, TDATA=0, busy=0, done=0, beats_sent=0, stop_pending=0. Table contents are not cleared.
- Handshake = TVALID & TREADY on a rising edge.
- IDLE:
  - start with num_entries!=0: latch n = min(num_entries, DEPTH) and loops_left = loop_count; idx=0; rep_left = max(repeat[0],1); TDATA = pattern[0]; TVALID=1; busy=1; beats_sent=0; go to SEND. First beat is valid in the cycle after start.
  - start with num_entries==0 is ignored: no busy, no done.
- SEND, on each handshake: beats_sent++.
  - If stop_pending: TVALID=0, done=1, go to IDLE.
  - Else if rep_left>1: rep_left--, TDATA unchanged.
  - Else if idx<n-1: idx++, load TDATA/rep_left from the new entry.
  - Else (end of pass):
    - If loops_left==1: TVALID=0, done=1, go to IDLE.
    - Else: if loops_left!=0, loops_left--; idx=0; reload entry 0.
  - The next beat is presented in the cycle after the handshake, giving back-to-back beats with no bubbles.
- SEND, no handshake: TVALID, TDATA, idx and rep_left hold. TVALID never drops without a handshake.
- stop:
  - In IDLE, ignored.
  - In SEND, sets stop_pending. The currently presented beat still completes; the stop takes effect at that handshake.
  - stop in the same cycle as a handshake stops at that handshake.
  - stop_pending clears on entering IDLE.
- start while busy: ignored. start and stop in the same cycle in IDLE: start wins and stop is ignored.
- done asserts for exactly one cycle, in the cycle after the final handshake, together with busy=0.
- Table writes:
  - Allowed at any time; the write takes effect at the next edge.
  - A running sequence sees new contents when it next loads that entry. The presented TDATA is never altered by a write.
  - A write and a read of the same entry on the same edge: the load reads the old value.
- Width rules: rep_left and loops_left are REPEAT_W bits; idx is ADDR_W bits; n is ADDR_W+1 bits. num_entries > DEPTH clamps to DEPTH.

Decomposition:
- Package pat_seq_pkg: state encoding (IDLE, SEND), PATTERN_WIDTH/ADDR_W/REPEAT_W defaults, helper for the clamp of n.
- Sub-module pat_table: DEPTH x (PATTERN_WIDTH+REPEAT_W) register file with one synchronous write port and one asynchronous read port.
- The sequencer FSM, counters and output registers live in pat_sequencer.

Test Plan:
- Write A=0x11111111/rep2 and B=0x22222222/rep1; n=2, loop=1, TREADY=1 → beats A,A,B on consecutive cycles; done pulses once the cycle after B; beats_sent=3.
- Same table, loop=3, TREADY toggling 1,0 → sequence A,A,B repeated 3 times (9 beats); TDATA stable on every stalled cycle; TVALID never drops mid-sequence.
- loop=0, n=1, entry 0 = 0xDEADBEEF/rep0 → continuous 0xDEADBEEF beats. Assert stop with TREADY=0 for 5 cycles, then TREADY=1 → exactly one more handshake, then TVALID=0 and done=1.
- Assert reset mid-SEND while TVALID=1 → next cycle TVALID=0, busy=0, beats_sent=0. A new start replays from entry 0 with the table intact.
- start with num_entries=0 → no TVALID, busy, or done. num_entries=20 with DEPTH=16 → 16 entries emitted per pass.
- During loop=2, rewrite entry 1 while entry 0 is being sent → pass 1 emits the new entry-1 value. A start pulse issued mid-run has no effect on the sequence or on beats_sent.

Source files
------------

// File: rtl/pat_seq_pkg.sv
// rtl/pat_seq_pkg.sv - shared types, default widths and helpers for the pattern sequencer
//
// Purpose: state encoding, default parameter values and the entry-count
// clamp used by pat_sequencer and pat_table.
package pat_seq_pkg;

  localparam int PATTERN_WIDTH_DEF = 32;
  localparam int ADDR_W_DEF        = 4;
  localparam int REPEAT_W_DEF      = 16;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } seq_state_e;

  // Entries used per pass: a request beyond the table depth uses the whole table.
  function automatic logic [31:0] clamp_entries(input logic [31:0] num,
                                                input logic [31:0] depth);
    return (num > depth) ? depth : num;
  endfunction

endpackage

// File: rtl/pat_table.sv
// rtl/pat_table.sv - pattern/repeat register file, one sync write port, one async read port
//
// Purpose: holds DEPTH entries of {pattern, repeat}. Contents are not reset.
// Ports:
//   clk           clock
//   wr_en_i       write strobe
//   wr_addr_i     entry written
//   wr_pattern_i  pattern value written
//   wr_repeat_i   repeat count written
//   rd_addr_i     entry read (combinational)
//   rd_pattern_o  pattern of rd_addr_i
//   rd_repeat_o   repeat count of rd_addr_i
module pat_table
  import pat_seq_pkg::*;
#(
  parameter int PATTERN_WIDTH = PATTERN_WIDTH_DEF,
  parameter int ADDR_W        = ADDR_W_DEF,
  parameter int REPEAT_W      = REPEAT_W_DEF
) (
  input  logic                     clk,
  input  logic                     wr_en_i,
  input  logic [ADDR_W-1:0]        wr_addr_i,
  input  logic [PATTERN_WIDTH-1:0] wr_pattern_i,
  input  logic [REPEAT_W-1:0]      wr_repeat_i,
  input  logic [ADDR_W-1:0]        rd_addr_i,
  output logic [PATTERN_WIDTH-1:0] rd_pattern_o,
  output logic [REPEAT_W-1:0]      rd_repeat_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [PATTERN_WIDTH-1:0] pattern_q [DEPTH];
  logic [REPEAT_W-1:0]      repeat_q  [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      pattern_q[wr_addr_i] <= wr_pattern_i;
      repeat_q[wr_addr_i]  <= wr_repeat_i;
    end
  end

  // Asynchronous read: a load and a write to the same entry on one edge
  // naturally sees the old contents.
  assign rd_pattern_o = pattern_q[rd_addr_i];
  assign rd_repeat_o  = repeat_q[rd_addr_i];

endmodule

// File: rtl/pat_sequencer.sv
// rtl/pat_sequencer.sv - table-driven pattern scheduler with AXI-Stream output
//
// Purpose: on start, streams table entries in order, each repeated per its
// repeat count, looping the table loop_count times (0 = forever).
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   cfg_wr/cfg_addr/cfg_pattern/cfg_repeat   table write port
//   num_entries, loop_count        run shape, sampled at start
//   start, stop                    single-cycle control requests
//   AXIS_OUT_TDATA/TVALID/TREADY   pattern stream to consumer
//   busy, done, beats_sent         status back to host
module pat_sequencer
  import pat_seq_pkg::*;
#(
  parameter int PATTERN_WIDTH = PATTERN_WIDTH_DEF,
  parameter int ADDR_W        = ADDR_W_DEF,
  parameter int REPEAT_W      = REPEAT_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cfg_wr,
  input  logic [ADDR_W-1:0]        cfg_addr,
  input  logic [PATTERN_WIDTH-1:0] cfg_pattern,
  input  logic [REPEAT_W-1:0]      cfg_repeat,
  input  logic [ADDR_W:0]          num_entries,
  input  logic [REPEAT_W-1:0]      loop_count,
  input  logic                     start,
  input  logic                     stop,
  output logic [PATTERN_WIDTH-1:0] AXIS_OUT_TDATA,
  output logic                     AXIS_OUT_TVALID,
  input  logic                     AXIS_OUT_TREADY,
  output logic                     busy,
  output logic                     done,
  output logic [31:0]              beats_sent
);

  localparam int DEPTH = 2 ** ADDR_W;

  seq_state_e               state_q, state_d;
  logic [ADDR_W-1:0]        idx_q, idx_d;
  logic [ADDR_W:0]          n_q, n_d;
  logic [REPEAT_W-1:0]      rep_left_q, rep_left_d;
  logic [REPEAT_W-1:0]      loops_left_q, loops_left_d;
  logic [PATTERN_WIDTH-1:0] tdata_q, tdata_d;
  logic                     tvalid_q, tvalid_d;
  logic                     done_q, done_d;
  logic [31:0]              beats_q, beats_d;
  logic                     stop_pending_q, stop_pending_d;

  logic                     hs;
  logic                     last_entry;
  logic [ADDR_W:0]          idx_plus1;
  logic [ADDR_W-1:0]        rd_addr;
  logic [PATTERN_WIDTH-1:0] rd_pattern;
  logic [REPEAT_W-1:0]      rd_repeat;
  logic [REPEAT_W-1:0]      rd_rep_eff;

  pat_table #(
    .PATTERN_WIDTH(PATTERN_WIDTH),
    .ADDR_W       (ADDR_W),
    .REPEAT_W     (REPEAT_W)
  ) u_table (
    .clk         (clk),
    .wr_en_i     (cfg_wr),
    .wr_addr_i   (cfg_addr),
    .wr_pattern_i(cfg_pattern),
    .wr_repeat_i (cfg_repeat),
    .rd_addr_i   (rd_addr),
    .rd_pattern_o(rd_pattern),
    .rd_repeat_o (rd_repeat)
  );

  assign hs         = tvalid_q & AXIS_OUT_TREADY;
  assign idx_plus1  = {1'b0, idx_q} + (ADDR_W + 1)'(1);
  assign last_entry = (idx_plus1 >= n_q);
  // The only entry ever loaded is either the next one in the pass or entry 0
  // (start, or wrap at end of pass), so the read address is fixed by position.
  assign rd_addr    = (state_q == S_SEND && !last_entry) ? idx_plus1[ADDR_W-1:0] : '0;
  assign rd_rep_eff = (rd_repeat == '0) ? REPEAT_W'(1) : rd_repeat;

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    n_d            = n_q;
    rep_left_d     = rep_left_q;
    loops_left_d   = loops_left_q;
    tdata_d        = tdata_q;
    tvalid_d       = tvalid_q;
    done_d         = 1'b0;
    beats_d        = beats_q;
    stop_pending_d = stop_pending_q;

    unique case (state_q)
      S_IDLE: begin
        if (start && num_entries != '0) begin
          state_d        = S_SEND;
          n_d            = (ADDR_W + 1)'(clamp_entries(32'(num_entries), 32'(DEPTH)));
          loops_left_d   = loop_count;
          idx_d          = '0;
          rep_left_d     = rd_rep_eff;
          tdata_d        = rd_pattern;
          tvalid_d       = 1'b1;
          beats_d        = '0;
          stop_pending_d = 1'b0;
        end
      end
      S_SEND: begin
        stop_pending_d = stop_pending_q | stop;
        if (hs) begin
          beats_d = beats_q + 32'd1;
          // A stop arriving on the handshake edge itself ends the run there.
          if (stop_pending_q || stop || (last_entry && rep_left_q <= REPEAT_W'(1)
                                          && loops_left_q == REPEAT_W'(1))) begin
            state_d        = S_IDLE;
            tvalid_d       = 1'b0;
            done_d         = 1'b1;
            stop_pending_d = 1'b0;
          end else if (rep_left_q > REPEAT_W'(1)) begin
            rep_left_d = rep_left_q - REPEAT_W'(1);
          end else begin
            if (last_entry) begin
              idx_d = '0;
              if (loops_left_q != '0) begin
                loops_left_d = loops_left_q - REPEAT_W'(1);
              end
            end else begin
              idx_d = idx_plus1[ADDR_W-1:0];
            end
            rep_left_d = rd_rep_eff;
            tdata_d    = rd_pattern;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      idx_q          <= '0;
      n_q            <= '0;
      rep_left_q     <= '0;
      loops_left_q   <= '0;
      tdata_q        <= '0;
      tvalid_q       <= 1'b0;
      done_q         <= 1'b0;
      beats_q        <= '0;
      stop_pending_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      n_q            <= n_d;
      rep_left_q     <= rep_left_d;
      loops_left_q   <= loops_left_d;
      tdata_q        <= tdata_d;
      tvalid_q       <= tvalid_d;
      done_q         <= done_d;
      beats_q        <= beats_d;
      stop_pending_q <= stop_pending_d;
    end
  end

  assign AXIS_OUT_TDATA  = tdata_q;
  assign AXIS_OUT_TVALID = tvalid_q;
  assign busy            = (state_q == S_SEND);
  assign done            = done_q;
  assign beats_sent      = beats_q;

endmodule

// File: tb/tb_pat_sequencer.sv
// tb/tb_pat_sequencer.sv - self-checking bench for pat_sequencer
module tb_pat_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_wr;
  logic [3:0]  cfg_addr;
  logic [31:0] cfg_pattern;
  logic [15:0] cfg_repeat;
  logic [4:0]  num_entries;
  logic [15:0] loop_count;
  logic        start;
  logic        stop;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        busy;
  logic        done;
  logic [31:0] beats_sent;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] m_pat [16];
  logic [15:0] m_rep [16];
  logic [31:0] exp_q [$];

  logic [3:0]  inj_addr;
  logic [31:0] inj_pat;
  logic [15:0] inj_rep;

  always #5 clk = ~clk;

  pat_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .cfg_wr         (cfg_wr),
    .cfg_addr       (cfg_addr),
    .cfg_pattern    (cfg_pattern),
    .cfg_repeat     (cfg_repeat),
    .num_entries    (num_entries),
    .loop_count     (loop_count),
    .start          (start),
    .stop           (stop),
    .AXIS_OUT_TDATA (tdata),
    .AXIS_OUT_TVALID(tvalid),
    .AXIS_OUT_TREADY(tready),
    .busy           (busy),
    .done           (done),
    .beats_sent     (beats_sent)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_entry(input logic [3:0] a, input logic [31:0] p, input logic [15:0] r);
    cfg_wr = 1'b1; cfg_addr = a; cfg_pattern = p; cfg_repeat = r;
    step();
    cfg_wr = 1'b0;
    m_pat[a] = p;
    m_rep[a] = r;
  endtask

  task automatic pulse_start(input logic [4:0] n, input logic [15:0] l);
    num_entries = n; loop_count = l; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Expected beat stream: each used entry emitted max(rep,1) times, per pass.
  task automatic build_exp(input int n, input int loops);
    int used;
    used = (n > 16) ? 16 : n;
    exp_q.delete();
    for (int l = 0; l < loops; l++)
      for (int i = 0; i < used; i++)
        for (int r = 0; r < ((m_rep[i] == 0) ? 1 : int'(m_rep[i])); r++)
          exp_q.push_back(m_pat[i]);
  endtask

  // mode 0: ready always, 1: ready toggles 1,0, 2: random. inj: cycle at which
  // a table write (inj_*) and a stray start are issued, -1 for none.
  task automatic drain(input int mode, input int inj);
    int cyc;
    int total;
    cyc = 0;
    total = exp_q.size();
    while (exp_q.size() > 0 && cyc < 2000) begin
      case (mode)
        0:       tready = 1'b1;
        1:       tready = (cyc % 2 == 0);
        default: tready = 1'($urandom_range(0, 1));
      endcase
      if (cyc == inj) begin
        cfg_wr = 1'b1; cfg_addr = inj_addr; cfg_pattern = inj_pat; cfg_repeat = inj_rep;
        start = 1'b1;
      end
      chk("tvalid_run", 64'(tvalid), 64'd1);
      chk("tdata_run", 64'(tdata), 64'(exp_q[0]));
      chk("busy_run", 64'(busy), 64'd1);
      chk("done_run", 64'(done), 64'd0);
      if (tvalid && tready) void'(exp_q.pop_front());
      step();
      cfg_wr = 1'b0;
      start = 1'b0;
      cyc++;
    end
    chk("drain_remaining", 64'(exp_q.size()), 64'd0);
    tready = $urandom_range(0, 1);
    chk("tvalid_end", 64'(tvalid), 64'd0);
    chk("done_end", 64'(done), 64'd1);
    chk("busy_end", 64'(busy), 64'd0);
    chk("beats_end", 64'(beats_sent), 64'(total));
    step();
    chk("done_after", 64'(done), 64'd0);
    chk("tvalid_after", 64'(tvalid), 64'd0);
  endtask

  initial begin
    int hs;
    reset = 1'b1; cfg_wr = 1'b0; cfg_addr = '0; cfg_pattern = '0; cfg_repeat = '0;
    num_entries = '0; loop_count = '0; start = 1'b0; stop = 1'b0; tready = 1'b0;
    inj_addr = '0; inj_pat = '0; inj_rep = '0;
    for (int i = 0; i < 16; i++) begin m_pat[i] = '0; m_rep[i] = '0; end
    step(); step();
    reset = 1'b0;

    chk("rst_tvalid", 64'(tvalid), 64'd0);
    chk("rst_tdata", 64'(tdata), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_beats", 64'(beats_sent), 64'd0);

    // A,A,B back to back with ready held high.
    write_entry(4'd0, 32'h11111111, 16'd2);
    write_entry(4'd1, 32'h22222222, 16'd1);
    pulse_start(5'd2, 16'd1);
    build_exp(2, 1);
    drain(0, -1);

    // Three passes with ready toggling.
    pulse_start(5'd2, 16'd3);
    build_exp(2, 3);
    drain(1, -1);

    // Endless single entry, repeat 0 means 1; stop while stalled.
    write_entry(4'd0, 32'hDEADBEEF, 16'd0);
    pulse_start(5'd1, 16'd0);
    hs = 0;
    for (int c = 0; c < 20; c++) begin
      tready = 1'($urandom_range(0, 1));
      chk("inf_tvalid", 64'(tvalid), 64'd1);
      chk("inf_tdata", 64'(tdata), 64'hDEADBEEF);
      if (tready) hs++;
      step();
    end
    tready = 1'b0;
    stop = 1'b1;
    for (int c = 0; c < 5; c++) begin
      chk("stall_tvalid", 64'(tvalid), 64'd1);
      chk("stall_done", 64'(done), 64'd0);
      step();
      stop = 1'b0;
    end
    tready = 1'b1;
    chk("stop_last_tdata", 64'(tdata), 64'hDEADBEEF);
    step();
    hs++;
    tready = 1'b0;
    chk("stop_tvalid", 64'(tvalid), 64'd0);
    chk("stop_done", 64'(done), 64'd1);
    chk("stop_busy", 64'(busy), 64'd0);
    chk("stop_beats", 64'(beats_sent), 64'(hs));
    step();
    chk("stop_done_after", 64'(done), 64'd0);

    // Reset in the middle of a run, then replay with the table intact.
    write_entry(4'd0, 32'h11111111, 16'd2);
    pulse_start(5'd2, 16'd0);
    tready = 1'b1;
    step(); step(); step();
    reset = 1'b1;
    tready = 1'b0;
    chk("pre_rst_tvalid", 64'(tvalid), 64'd1);
    step();
    reset = 1'b0;
    chk("midrst_tvalid", 64'(tvalid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_beats", 64'(beats_sent), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    pulse_start(5'd2, 16'd1);
    build_exp(2, 1);
    drain(2, -1);

    // Start with zero entries is ignored.
    pulse_start(5'd0, 16'd1);
    for (int c = 0; c < 3; c++) begin
      chk("zero_tvalid", 64'(tvalid), 64'd0);
      chk("zero_busy", 64'(busy), 64'd0);
      chk("zero_done", 64'(done), 64'd0);
      step();
    end

    // num_entries beyond depth clamps to the full table; random contents.
    for (int i = 0; i < 16; i++)
      write_entry(4'(i), $urandom, 16'($urandom_range(0, 2)));
    pulse_start(5'd20, 16'd2);
    build_exp(20, 2);
    drain(2, -1);

    // Rewrite entry 1 while entry 0 is on the wire; stray start mid-run.
    write_entry(4'd0, $urandom, 16'd3);
    write_entry(4'd1, $urandom, 16'd1);
    pulse_start(5'd2, 16'd2);
    inj_addr = 4'd1;
    inj_pat  = $urandom;
    inj_rep  = 16'd2;
    m_pat[1] = inj_pat;
    m_rep[1] = inj_rep;
    build_exp(2, 2);
    drain(2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
